// File: rtl/spi_reg_ctrl.sv
// Byte-level SPI command controller: decodes one command byte per chip
// select, then streams register reads (address auto-increment, coherent
// position snapshot) or register writes.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned POS_W   = 32,
    parameter logic [7:0]  ID_BYTE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_ss,
    input  logic             spi_done,
    input  logic [7:0]       spi_rx,
    output logic [7:0]       spi_tx,
    input  logic [POS_W-1:0] pos,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic [7:0]       led_reg,
    output logic             xfer_active
);

    typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

    state_t            state, state_n;
    logic              ss_m, ss_s, ss_d;
    logic              ss_fall, ss_rise;
    logic [POS_W-1:0]  snapshot, snapshot_n;
    logic [7:0]        scratch, scratch_n;
    logic [7:0]        txn_count, txn_count_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        tx_n, led_n;
    logic              cnt_enable_n, cnt_clear_n;

    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_snap;
    logic [7:0]        rd_data;
    logic [31:0]       pos_ext, snap_ext;

    // Synchronizer resets low: a select still held across reset produces no
    // falling edge, so the next transaction needs a fresh ss assertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_m <= 1'b0;
            ss_s <= 1'b0;
            ss_d <= 1'b0;
        end else begin
            ss_m <= spi_ss;
            ss_s <= ss_m;
            ss_d <= ss_s;
        end
    end

    assign ss_fall     = ss_d & ~ss_s;
    assign ss_rise     = ~ss_d & ss_s;
    assign xfer_active = (state != IDLE);

    // Zero-extend position and snapshot so bytes at or above POS_W/8 read 0.
    always_comb begin
        pos_ext  = '0;
        snap_ext = '0;
        pos_ext[POS_W-1:0]  = pos;
        snap_ext[POS_W-1:0] = snapshot;
    end

    // The command byte reads through the live position (it is the value the
    // snapshot captures in that same cycle); streamed reads use the snapshot.
    always_comb begin
        rd_addr = (state == CMD) ? spi_rx[ADDR_W-1:0] : addr;
        rd_snap = (state == CMD) ? pos_ext : snap_ext;
        rd_data = 8'h00;
        if (rd_addr < ADDR_W'(4)) begin
            rd_data = rd_snap[{rd_addr[1:0], 3'b000} +: 8];
        end else begin
            case (rd_addr)
                ADDR_W'(4): rd_data = txn_count;
                ADDR_W'(5): rd_data = {7'b0, cnt_enable};
                ADDR_W'(6): rd_data = led_reg;
                ADDR_W'(7): rd_data = scratch;
                default:    rd_data = 8'h00;
            endcase
        end
    end

    // Next-state and register-update logic; deselect overrides a coincident byte.
    always_comb begin
        state_n      = state;
        tx_n         = spi_tx;
        snapshot_n   = snapshot;
        scratch_n    = scratch;
        txn_count_n  = txn_count;
        addr_n       = addr;
        led_n        = led_reg;
        cnt_enable_n = cnt_enable;
        cnt_clear_n  = 1'b0;
        if (state == IDLE) begin
            tx_n = ID_BYTE;
            if (ss_fall) state_n = CMD;
        end else if (ss_rise) begin
            state_n     = IDLE;
            tx_n        = ID_BYTE;
            txn_count_n = txn_count + 8'd1;
        end else if (spi_done) begin
            case (state)
                CMD: begin
                    if (spi_rx[7]) begin
                        addr_n  = spi_rx[ADDR_W-1:0];
                        tx_n    = 8'h00;
                        state_n = WR;
                    end else begin
                        snapshot_n = pos;
                        tx_n       = rd_data;
                        addr_n     = spi_rx[ADDR_W-1:0] + ADDR_W'(1);
                        state_n    = RD;
                    end
                end
                RD: begin
                    tx_n   = rd_data;
                    addr_n = addr + ADDR_W'(1);
                end
                WR: begin
                    case (addr)
                        ADDR_W'(5): begin
                            cnt_enable_n = spi_rx[0];
                            cnt_clear_n  = spi_rx[1];
                        end
                        ADDR_W'(6): led_n     = spi_rx;
                        ADDR_W'(7): scratch_n = spi_rx;
                        default:    ;
                    endcase
                    addr_n = addr + ADDR_W'(1);
                    tx_n   = 8'h00;
                end
                default: ;
            endcase
        end
    end

    // State and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            spi_tx     <= ID_BYTE;
            snapshot   <= '0;
            scratch    <= '0;
            txn_count  <= '0;
            addr       <= '0;
            led_reg    <= '0;
            cnt_enable <= 1'b1;
            cnt_clear  <= 1'b0;
        end else begin
            state      <= state_n;
            spi_tx     <= tx_n;
            snapshot   <= snapshot_n;
            scratch    <= scratch_n;
            txn_count  <= txn_count_n;
            addr       <= addr_n;
            led_reg    <= led_n;
            cnt_enable <= cnt_enable_n;
            cnt_clear  <= cnt_clear_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: byte-level SPI transactions with
// hand-computed expected register and transmit values.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_ss = 1'b1;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;
    logic [7:0]  spi_tx;
    logic [31:0] pos = 32'h0;
    logic        cnt_enable;
    logic        cnt_clear;
    logic [7:0]  led_reg;
    logic        xfer_active;

    int unsigned checks = 0;
    int unsigned errors = 0;

    spi_reg_ctrl #(.ADDR_W(7), .POS_W(32), .ID_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .spi_ss(spi_ss), .spi_done(spi_done),
        .spi_rx(spi_rx), .spi_tx(spi_tx), .pos(pos),
        .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
        .led_reg(led_reg), .xfer_active(xfer_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One received byte: done pulse for one cycle, returns at the negedge
    // right after the capturing posedge so registered outputs are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        spi_rx   = b;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        spi_rx   = 8'h00;
    endtask

    task automatic select_on;
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic select_off;
        @(negedge clk);
        spi_ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", spi_tx, 8'hA5);
        chk("rst_en", cnt_enable, 1);
        chk("rst_clr", cnt_clear, 0);
        chk("rst_led", led_reg, 8'h00);
        chk("rst_xfer", xfer_active, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Empty select: counted, ID byte throughout
        select_on();
        chk("empty_xfer", xfer_active, 1);
        chk("empty_tx", spi_tx, 8'hA5);
        select_off();
        chk("empty_xfer_off", xfer_active, 0);
        chk("empty_tx_off", spi_tx, 8'hA5);

        // Read txn_count (1 so far)
        select_on();
        send(8'h04);
        chk("txn_1", spi_tx, 8'h01);
        select_off();
        chk("txn_idle_tx", spi_tx, 8'hA5);

        // Coherent snapshot read; pos changes mid-stream
        pos = 32'h1234_5678;
        select_on();
        send(8'h00);
        chk("snap_b0", spi_tx, 8'h78);
        pos = 32'hFFFF_0000;
        send(8'hFF);
        chk("snap_b1", spi_tx, 8'h56);
        send(8'hFF);
        chk("snap_b2", spi_tx, 8'h34);
        send(8'hFF);
        chk("snap_b3", spi_tx, 8'h12);
        send(8'hFF);
        chk("snap_txn", spi_tx, 8'h02);
        select_off();

        // Writes to led then scratch
        select_on();
        send(8'h86);
        chk("wr_cmd_tx", spi_tx, 8'h00);
        send(8'h3C);
        chk("wr_led", led_reg, 8'h3C);
        chk("wr_tx", spi_tx, 8'h00);
        send(8'hC3);
        chk("wr_led_hold", led_reg, 8'h3C);
        select_off();

        select_on();
        send(8'h06);
        chk("rd_led", spi_tx, 8'h3C);
        send(8'h00);
        chk("rd_scratch", spi_tx, 8'hC3);
        send(8'h00);
        chk("rd_unmapped", spi_tx, 8'h00);
        select_off();

        // Control: clear strobe with disable
        select_on();
        send(8'h85);
        send(8'h02);
        chk("clr_pulse", cnt_clear, 1);
        chk("clr_en", cnt_enable, 0);
        @(negedge clk);
        chk("clr_pulse_end", cnt_clear, 0);
        select_off();

        select_on();
        send(8'h05);
        chk("rd_ctrl", spi_tx, 8'h00);
        select_off();

        select_on();
        send(8'h85);
        send(8'h01);
        chk("en_noclr", cnt_clear, 0);
        chk("en_set", cnt_enable, 1);
        @(negedge clk);
        chk("en_noclr2", cnt_clear, 0);
        select_off();

        // Address wrap 0x7F -> 0x00
        pos = 32'h1234_5678;
        select_on();
        send(8'h7F);
        chk("wrap_7f", spi_tx, 8'h00);
        send(8'h00);
        chk("wrap_00", spi_tx, 8'h78);
        send(8'h00);
        chk("wrap_01", spi_tx, 8'h56);
        select_off();

        // Deselect coincident with a byte: byte discarded
        select_on();
        send(8'h86);
        @(negedge clk);
        spi_ss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spi_rx   = 8'h99;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("coinc_led", led_reg, 8'h3C);
        chk("coinc_idle", xfer_active, 0);

        // Reset during write data phase
        select_on();
        send(8'h86);
        send(8'h55);
        chk("pre_rst_led", led_reg, 8'h55);
        #1 rst = 1'b1;
        #1;
        chk("arst_tx", spi_tx, 8'hA5);
        chk("arst_led", led_reg, 8'h00);
        chk("arst_en", cnt_enable, 1);
        chk("arst_clr", cnt_clear, 0);
        chk("arst_xfer", xfer_active, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_ss_idle", xfer_active, 0);
        select_off();

        select_on();
        send(8'h86);
        send(8'hAA);
        chk("post_rst_led", led_reg, 8'hAA);
        select_off();

        select_on();
        send(8'h04);
        chk("post_rst_txn", spi_tx, 8'h01);
        select_off();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
